// File: rtl/snake_pkg.sv
// Shared types, key codes and key decode for the snake game command path.
// Pure declarations; no logic latency and no flow control of its own.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        WAIT  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } ctrl_state_t;

    localparam logic [7:0] KC_UP      = 8'h18;
    localparam logic [7:0] KC_DOWN    = 8'h19;
    localparam logic [7:0] KC_LEFT    = 8'h1B;
    localparam logic [7:0] KC_RIGHT   = 8'h1A;
    localparam logic [7:0] KC_PAUSE   = 8'h50;
    localparam logic [7:0] KC_RESTART = 8'h52;
    localparam logic [7:0] KC_W       = 8'h57;
    localparam logic [7:0] KC_S       = 8'h53;
    localparam logic [7:0] KC_A       = 8'h41;
    localparam logic [7:0] KC_D       = 8'h44;

    // Returns {is_direction, direction}.
    function automatic logic [2:0] decode_dir(input logic [7:0] kc);
        logic [2:0] r;
        r = 3'b000;
        case (kc)
            KC_UP:    r = {1'b1, UP};
            KC_DOWN:  r = {1'b1, DOWN};
            KC_LEFT:  r = {1'b1, LEFT};
            KC_RIGHT: r = {1'b1, RIGHT};
`ifdef KEY_WASD_EN
            KC_W:     r = {1'b1, UP};
            KC_S:     r = {1'b1, DOWN};
            KC_A:     r = {1'b1, LEFT};
            KC_D:     r = {1'b1, RIGHT};
`endif
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small direction queue with flush and tail (last) output; head is combinational.
// Write lands next cycle; a push while full is taken only with a simultaneous pop.
module dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [1:0] last,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW-1:0] last_idx;
    logic [1:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign last_idx = wptr_q[AW-1:0] - AW'(1);
    assign head     = mem_q[rptr_q[AW-1:0]];
    assign last     = mem_q[last_idx];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns key events into queued direction changes and run/pause/restart control; KEY_WASD_EN adds WASD keys.
// Inputs act one cycle after they change, step follows tick by one cycle; a full queue drops pushes (sticky q_overflow).
module key_cmd_scheduler
    import snake_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [1:0] START_DIR = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_state,
    input  logic [7:0] key_code,
    input  logic       tick,
    output logic       step,
    output logic [1:0] dir,
    output logic       restart,
    output logic       running,
    output logic       paused,
    output logic       q_overflow
);
    ctrl_state_t state_q, state_d;
    dir_t        dir_q, dir_d;
    logic        key_state_q;
    logic [7:0]  key_code_q;
    logic        step_q, restart_q, ovf_q, ovf_d;

    logic        key_ev, dir_ev, p_ev, r_ev;
    logic [2:0]  dec;
    logic        do_step, can_push;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]  fifo_head, fifo_last, newest;

    // A held key only counts again if the code changes (typematic repeats are ignored).
    assign key_ev = key_state && (!key_state_q || (key_code != key_code_q));
    assign dec    = decode_dir(key_code);
    assign dir_ev = key_ev && dec[2];
    assign p_ev   = key_ev && (key_code == KC_PAUSE);
    assign r_ev   = key_ev && (key_code == KC_RESTART);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (r_ev) begin
            state_d = WAIT;
        end else begin
            case (state_q)
                WAIT:    if (dir_ev) state_d = RUN;
                RUN:     if (p_ev)   state_d = PAUSE;
                PAUSE:   if (p_ev)   state_d = RUN;
                default: state_d = WAIT;
            endcase
        end
    end

    always_comb begin
        running  = (state_q == RUN);
        paused   = (state_q == PAUSE);
        do_step  = (state_q == RUN) && tick && !r_ev;
        can_push = dir_ev && (state_q != PAUSE);
    end

    // Duplicate filter compares against the tail, or the live direction when nothing is queued.
    assign newest    = fifo_empty ? dir_q : fifo_last;
    assign fifo_pop  = do_step && !fifo_empty;
    assign fifo_push = can_push && (dec[1:0] != newest);

    always_comb begin
        dir_d = dir_q;
        ovf_d = ovf_q;
        if (r_ev) begin
            dir_d = dir_t'(START_DIR);
            ovf_d = 1'b0;
        end else begin
            if (fifo_pop && (fifo_head != (dir_q ^ 2'b01))) dir_d = dir_t'(fifo_head);
            if (fifo_push && fifo_full && !fifo_pop)         ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_q <= 1'b0;
            key_code_q  <= 8'h00;
            dir_q       <= dir_t'(START_DIR);
            step_q      <= 1'b0;
            restart_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            key_state_q <= key_state;
            key_code_q  <= key_code;
            dir_q       <= dir_d;
            step_q      <= do_step;
            restart_q   <= r_ev;
            ovf_q       <= ovf_d;
        end
    end

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_dir_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (r_ev),
        .din   (dec[1:0]),
        .head  (fifo_head),
        .last  (fifo_last),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign step       = step_q;
    assign dir        = dir_q;
    assign restart    = restart_q;
    assign q_overflow = ovf_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_key_cmd_scheduler;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_state = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       tick = 1'b0;
    logic       step, restart, running, paused, q_overflow;
    logic [1:0] dir;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    int         m_state;  // 0 wait, 1 run, 2 pause
    logic       m_step, m_restart, m_ovf, m_ksd;
    logic [7:0] m_kcd;

    key_cmd_scheduler #(.DEPTH(DEPTH), .START_DIR(2'b11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_state  (key_state),
        .key_code   (key_code),
        .tick       (tick),
        .step       (step),
        .dir        (dir),
        .restart    (restart),
        .running    (running),
        .paused     (paused),
        .q_overflow (q_overflow)
    );

    always #10 clk = ~clk;

    function automatic int map_dir(input logic [7:0] kc);
        case (kc)
            8'h18: return 0;
            8'h19: return 1;
            8'h1B: return 2;
            8'h1A: return 3;
`ifdef KEY_WASD_EN
            8'h57: return 0;
            8'h53: return 1;
            8'h41: return 2;
            8'h44: return 3;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_dir = 2'b11;
        m_state = 0;
        m_step = 1'b0;
        m_restart = 1'b0;
        m_ovf = 1'b0;
        m_ksd = 1'b0;
        m_kcd = 8'h00;
    endtask

    task automatic model_update(input logic ks, input logic [7:0] kc, input logic tk);
        bit         ev;
        int         d;
        bit         stepping, pushing, popping, was_full;
        logic [1:0] newest, h;
        ev = ks && (!m_ksd || kc != m_kcd);
        d = map_dir(kc);
        m_step = 1'b0;
        m_restart = 1'b0;
        if (ev && kc == 8'h52) begin
            m_q.delete();
            m_dir = 2'b11;
            m_ovf = 1'b0;
            m_restart = 1'b1;
            m_state = 0;
        end else begin
            stepping = (m_state == 1) && tk;
            pushing  = ev && (d >= 0) && (m_state != 2);
            newest   = (m_q.size() > 0) ? m_q[$] : m_dir;
            popping  = stepping && (m_q.size() > 0);
            was_full = (m_q.size() == DEPTH);
            if (stepping) m_step = 1'b1;
            if (popping) begin
                h = m_q.pop_front();
                if (h != (m_dir ^ 2'b01)) m_dir = h;
            end
            if (pushing && d[1:0] != newest) begin
                if (was_full && !popping) m_ovf = 1'b1;
                else m_q.push_back(d[1:0]);
            end
            if (pushing && m_state == 0) m_state = 1;
            else if (ev && kc == 8'h50) begin
                if (m_state == 1) m_state = 2;
                else if (m_state == 2) m_state = 1;
            end
        end
        m_ksd = ks;
        m_kcd = kc;
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic drive(input logic ks, input logic [7:0] kc, input logic tk);
        key_state = ks;
        key_code = kc;
        tick = tk;
        model_update(ks, kc, tk);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] kc);
        drive(1'b1, kc, 1'b0);
        drive(1'b0, kc, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_state = 1'b0; key_code = 8'h00; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({step, restart, running, paused, q_overflow} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {step, restart, running, paused, q_overflow}); end
        n_vec++; if (dir !== 2'b11) begin n_err++; $display("FAIL reset_dir got %b want 11", dir); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        drive(1'b1, 8'h1A, 1'b0);
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running got %b want 1", running); end
        n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL start_nostep got %b want 0", step); end
        drive(1'b0, 8'h1A, 1'b1);
        n_vec++; if (step !== 1'b1 || dir !== 2'b11) begin n_err++; $display("FAIL start_step got step=%b dir=%b want step=1 dir=11", step, dir); end
        drive(1'b0, 8'h1A, 1'b0);
        n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL start_pulse got %b want 0", step); end
    endtask

    task automatic test_turns();
        press(8'h18);
        press(8'h1B);
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b00 || step !== 1'b1) begin n_err++; $display("FAIL turn1 got dir=%b step=%b want dir=00 step=1", dir, step); end
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b10 || step !== 1'b1) begin n_err++; $display("FAIL turn2 got dir=%b step=%b want dir=10 step=1", dir, step); end
    endtask

    task automatic test_reversal();
        drive(1'b1, 8'h52, 1'b0);
        n_vec++; if (restart !== 1'b1 || dir !== 2'b11) begin n_err++; $display("FAIL rev_restart got restart=%b dir=%b want 1/11", restart, dir); end
        drive(1'b0, 8'h52, 1'b0);
        press(8'h1A);
        press(8'h1B);
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b11 || step !== 1'b1) begin n_err++; $display("FAIL reversal got dir=%b step=%b want dir=11 step=1", dir, step); end
        press(8'h18);
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b00) begin n_err++; $display("FAIL rev_empty got dir=%b want 00", dir); end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_dirs [5];
        exp_dirs[0] = 2'b00; exp_dirs[1] = 2'b00; exp_dirs[2] = 2'b00;
        exp_dirs[3] = 2'b11; exp_dirs[4] = 2'b11;
        drive(1'b1, 8'h52, 1'b0);
        drive(1'b0, 8'h52, 1'b0);
        press(8'h1A);
        press(8'h18); press(8'h19); press(8'h18); press(8'h19);
        n_vec++; if (q_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_four got %b want 0", q_overflow); end
        press(8'h1B);
        n_vec++; if (q_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", q_overflow); end
        drive(1'b1, 8'h1A, 1'b1);
        n_vec++; if (dir !== 2'b00 || step !== 1'b1) begin n_err++; $display("FAIL ovf_pushpop got dir=%b step=%b want dir=00 step=1", dir, step); end
        drive(1'b0, 8'h1A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_vec++; if (dir !== exp_dirs[i]) begin n_err++; $display("FAIL ovf_drain%0d got dir=%b want %b", i, dir, exp_dirs[i]); end
        end
    endtask

    task automatic test_pause();
        press(8'h18);
        press(8'h50);
        n_vec++; if (paused !== 1'b1 || running !== 1'b0) begin n_err++; $display("FAIL pause_enter got paused=%b running=%b want 1/0", paused, running); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h50, 1'b1);
            n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL pause_tick%0d got step=%b want 0", i, step); end
        end
        press(8'h1B);
        press(8'h50);
        n_vec++; if (running !== 1'b1 || paused !== 1'b0) begin n_err++; $display("FAIL pause_exit got running=%b paused=%b want 1/0", running, paused); end
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b00 || step !== 1'b1) begin n_err++; $display("FAIL pause_held got dir=%b step=%b want 00/1", dir, step); end
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b00) begin n_err++; $display("FAIL pause_noqueue got dir=%b want 00", dir); end
    endtask

    task automatic test_restart();
        press(8'h1B); press(8'h1A); press(8'h1B);
        n_vec++; if (q_overflow !== 1'b1) begin n_err++; $display("FAIL rst_pre_ovf got %b want 1", q_overflow); end
        drive(1'b1, 8'h52, 1'b1);
        n_vec++; if (restart !== 1'b1 || step !== 1'b0 || dir !== 2'b11) begin n_err++; $display("FAIL rst_pulse got restart=%b step=%b dir=%b want 1/0/11", restart, step, dir); end
        n_vec++; if (running !== 1'b0 || paused !== 1'b0 || q_overflow !== 1'b0) begin n_err++; $display("FAIL rst_state got run=%b pause=%b ovf=%b want 0/0/0", running, paused, q_overflow); end
        drive(1'b0, 8'h52, 1'b1);
        n_vec++; if (restart !== 1'b0 || step !== 1'b0) begin n_err++; $display("FAIL rst_wait got restart=%b step=%b want 0/0", restart, step); end
        press(8'h18);
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b00) begin n_err++; $display("FAIL rst_first got dir=%b want 00", dir); end
        drive(1'b0, 8'h00, 1'b1);
        n_vec++; if (dir !== 2'b00) begin n_err++; $display("FAIL rst_flushed got dir=%b want 00", dir); end
    endtask

    task automatic test_random();
        logic [7:0] kc;
        logic       ks, tk;
        int         r;
        kc = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 31);
                if (r < 16)      kc = (r % 4 == 0) ? 8'h18 : (r % 4 == 1) ? 8'h19 : (r % 4 == 2) ? 8'h1B : 8'h1A;
                else if (r < 18) kc = 8'h50;
                else if (r == 18) kc = 8'h52;
                else if (r < 23) kc = (r == 19) ? 8'h57 : (r == 20) ? 8'h53 : (r == 21) ? 8'h41 : 8'h44;
                else             kc = 8'($urandom_range(0, 255));
            end
            ks = ($urandom_range(0, 9) < 6);
            tk = ($urandom_range(0, 3) == 0);
            drive(ks, kc, tk);
            n_vec++; if (step !== m_step) begin n_err++; $display("FAIL rnd_step cyc %0d got %b want %b", i, step, m_step); end
            n_vec++; if (dir !== m_dir) begin n_err++; $display("FAIL rnd_dir cyc %0d got %b want %b", i, dir, m_dir); end
            n_vec++; if (restart !== m_restart) begin n_err++; $display("FAIL rnd_restart cyc %0d got %b want %b", i, restart, m_restart); end
            n_vec++; if (running !== (m_state == 1) || paused !== (m_state == 2)) begin n_err++; $display("FAIL rnd_state cyc %0d got run=%b pause=%b want state %0d", i, running, paused, m_state); end
            n_vec++; if (q_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, q_overflow, m_ovf); end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                n_vec++; if ({step, restart, running, paused, q_overflow, dir} !== 7'b0000011) begin n_err++; $display("FAIL rnd_async_reset got %b want 0000011", {step, restart, running, paused, q_overflow, dir}); end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_turns();
        test_reversal();
        test_overflow();
        test_pause();
        test_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_cmd_scheduler.md
# key_cmd_scheduler

Sequences decoded PS/2 key events into game commands for the snake core. Sits between the keyboard receiver (level `key_state` plus ASCII-mapped `key_code`) and the game engine. It queues direction presses and releases at most one direction change per game tick, rejecting reversals. It also runs the run/pause/restart state machine that gates the game step.

## Interface
Parameters:
- `DEPTH`, 4: direction queue entries; power of two, 2..16.
- `START_DIR`, 2'b11: direction loaded on reset and on restart (RIGHT).

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `key_state`  in  1  level from the receiver; 1 while a key is held.
- `key_code`  in  8  ASCII code of the last pressed key.
- `tick`  in  1  single-cycle game-step request from the frame timer.
- `step`  out  1  single-cycle pulse; the engine advances one cell. Reset 0.
- `dir`  out  2  current direction: 00 up, 01 down, 10 left, 11 right. Reset `START_DIR`.
- `restart`  out  1  single-cycle pulse; the engine clears the board. Reset 0.
- `running`  out  1  1 in RUN. Reset 0.
- `paused`  out  1  1 in PAUSE. Reset 0.
- `q_overflow`  out  1  sticky flag; a direction was dropped because the queue was full. Cleared by restart. Reset 0.

## Operation
- **Press event.** Registered `key_state_d` and `key_code_d`, both reset 0. An event occurs on either:
  - a rising edge of `key_state`, or
  - `key_state`=1 with `key_code` != `key_code_d`.
  - Typematic repeats of the same code produce no event.
- **Key map.**
  - 0x18 = up, 0x19 = down, 0x1B = left, 0x1A = right.
  - 0x50 ('P') = pause toggle.
  - 0x52 ('R') = restart.
  - All other codes are ignored.
- **States.**
  - WAIT (reset state): the first direction event enqueues that direction and moves to RUN. 'P' is ignored.
  - RUN: `tick` generates a step. 'P' moves to PAUSE.
  - PAUSE: `tick` is ignored; direction events are ignored (not queued). 'P' returns to RUN.
  - 'R' in any state: flush the queue, set `dir`=`START_DIR`, clear `q_overflow`, pulse `restart`, go to WAIT.
- **Queue push** (direction event in WAIT or RUN):
  - Dropped if equal to the most recently enqueued entry. When the queue is empty, the comparison is against `dir`.
  - Dropped if the queue is full; `q_overflow` sets.
  - Full with a simultaneous pop: the push is accepted.
- **Queue pop** (`tick` in RUN, queue non-empty): the head is removed.
  - If head != (`dir` ^ 2'b01), `dir` takes the head.
  - Otherwise the reversal is discarded and `dir` is unchanged.
  - Only one entry is consumed per tick.
- **Pointers.** Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are derived from the MSB and the remaining bits.

## Timing
- Event detect: 1 cycle after the `key_state`/`key_code` change, the queue and state update.
- The `tick` seen at cycle N produces `dir` updated at N+1 and `step`=1 at N+1. `dir` is stable for the whole `step` cycle.
- `restart` is high for exactly one cycle, the cycle after 'R' is seen. `step` is never asserted in that cycle.
- `tick` and 'R' in the same cycle: restart wins; no step, and the queue is flushed.
- `tick` and 'P' in the same cycle in RUN: the step is issued, and the state becomes PAUSE.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous). The queue is emptied.

## Configuration
- `KEY_WASD_EN`
  - Defined: 0x57/0x53/0x41/0x44 (W/S/A/D) also map to up/down/left/right, with identical queue behaviour.
  - Undefined: only the arrow codes are directions, and W/S/A/D are ignored.

## Structure
- Package `snake_pkg`:
  - direction enum `dir_t` (UP, DOWN, LEFT, RIGHT with the encodings above);
  - state enum `ctrl_state_t` (WAIT, RUN, PAUSE);
  - localparams for the key codes (`KC_UP`, `KC_DOWN`, `KC_LEFT`, `KC_RIGHT`, `KC_PAUSE`, `KC_RESTART`, `KC_W`/`KC_S`/`KC_A`/`KC_D`).
- Sub-module `dir_fifo`: a DEPTH-parameterised synchronous FIFO with push/pop/flush, full/empty and `last` (tail value) outputs. The state machine, event detect and reversal filter live in the top module.

## Test plan
- Reset, then key_state↑ with 0x1A, then a tick: `running`=1; `step` one cycle after the tick with `dir`=11.
- In RUN with `dir`=11, queue 0x18 then 0x1B, then two ticks: `dir`=00 after tick 1, and 10 after tick 2.
- `dir`=11, queue 0x1B, then a tick: the entry is discarded, `dir` stays 11, `step` still pulses, and the queue is empty.
- With DEPTH=4 and no ticks, push up, down, up, down, left: 4 entries are held and `q_overflow`=1. Push and tick on the same cycle when full: the push is accepted and the count stays 4.
- 'P' in RUN, then 3 ticks and an arrow: no `step`, `paused`=1, the queue is unchanged. A second 'P' returns to RUN.
- 'R' with the queue holding 3 entries, coincident with a tick: one `restart` pulse, no `step`, `dir`=11, the queue is empty, state is WAIT, and `q_overflow`=0.
